ff_2_sync: RTL and testbench
============================

// Module: ff_2_sync
// PURPOSE
// - Multi-bit two-flop synchronizer. Brings D1, launched from a foreign clock domain, into the clk domain.
// - Used on FIFO Gray-coded read/write pointers crossing between domains, one instance per direction.
// - No logic between stages; output ff2 is the registered, metastability-filtered copy of D1.
// PARAMETERS
// - Width       4   bit width of D1/ff2 (>=1)
// - SYNC_STAGES 2   number of flop stages (>=2); default gives the classic 2-FF sync
// - RST_VAL     0   value loaded into every stage on reset (Width bits, zero-extended)
// PORTS
// - clk  input   1      destination-domain clock, rising-edge active
// - rst  input   1      reset: one clock; reset is synchronous and active-high
// - D1   input   Width  asynchronous data from source domain (Gray-coded when multi-bit)
// - ff2  output  Width  synchronized data, registered
// BEHAVIOUR
// - Reset: on a rising clk edge with rst=1, every stage (ff1..ffN) loads RST_VAL; ff2 = RST_VAL
//   (default 0) from that edge onward. No asynchronous clear; rst sampled only at clk edges.
// - Normal: each rising edge with rst=0: stage1 <= D1; stage k <= stage k-1; ff2 = last stage.
// - Latency: a D1 change stable before edge n appears on ff2 after edge n+SYNC_STAGES-1
//   (edge n+1 for default 2 stages). No combinational path D1 -> ff2.
// - Bits are synchronized independently; no cross-bit coherency guarantee. Callers pass
//   Gray-coded or otherwise single-bit-change values.
// - A D1 pulse shorter than one clk period may be missed; not an error. Pulses held >= 1
//   period plus setup always appear on ff2 for the same number of cycles.
// - Reset mid-operation: contents flushed to RST_VAL on the reset edge; the first D1 sample
//   after rst deasserts propagates with the normal latency. rst has priority over D1.
// - X on D1 during reset does not reach ff2.
// - Elaboration check: SYNC_STAGES < 2 or Width < 1 -> $error / fatal at elaboration.
// - Stage flops carry the synthesis attribute ASYNC_REG="TRUE" (or tool equivalent), placed
//   adjacent; no reset or enable fan-in beyond rst.
// STRUCTURE
// - Shared package fifo_pkg: default SYNC_STAGES constant, default pointer width constant.
// - One sub-module: sync_cell (single-bit SYNC_STAGES-deep shift chain with sync reset and
//   RST bit); ff_2_sync instantiates Width copies via generate loop, bit i of RST_VAL to cell i.
// - Internal stage array stage[0..SYNC_STAGES-1][Width-1:0]; first stage named ff1, output ff2.
// TESTING (clk period 10 ns, Width=4, defaults)
// 1. Reset: rst=1 two edges, D1=4'b1111 -> ff2=4'b0000 throughout; held while rst=1.
// 2. Latency: rst=0, D1 0->4'b0001 before edge n -> ff2=4'b0000 after edge n,
//    4'b0001 after edge n+1.
// 3. Toggle train: D1 = 1,0,1,0 each held 10 ns -> ff2 replays 1,0,1,0 delayed by 2 edges, no glitch.
// 4. Reset mid-stream: D1=4'b1010 steady, rst=1 for one edge -> ff2=0 next edge;
//    rst=0 -> ff2=4'b1010 two edges later.
// 5. Gray count: D1 steps 0000,0001,0011,0010,0110 per cycle -> ff2 same sequence,
//    2-cycle shift, one bit change per cycle.
// 6. Param sweep: Width=1 and SYNC_STAGES=3 -> latency 3 edges, reset value honoured with RST_VAL=1.

Source files
------------

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared FIFO clock-domain-crossing constants
// Purpose: defaults shared by the FIFO pointer synchronizers.
// Ports: none (package).
package fifo_pkg;

  // Classic two-flop synchronizer depth.
  localparam int SYNC_STAGES_DEF = 2;

  // Default Gray-coded pointer width crossing between domains.
  localparam int PTR_WIDTH_DEF = 4;

endpackage : fifo_pkg

// File: rtl/sync_cell.sv
// rtl/sync_cell.sv - single-bit multi-stage synchronizer chain
// Purpose: shifts one asynchronous bit through STAGES back-to-back flops.
// Ports:
//   clk  - destination-domain clock, rising edge
//   rst  - synchronous active-high reset, loads RST_BIT into every stage
//   d_i  - asynchronous input bit
//   q_o  - last stage, metastability-filtered copy of d_i
module sync_cell
  import fifo_pkg::*;
#(
  parameter int   STAGES  = SYNC_STAGES_DEF,
  parameter logic RST_BIT = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  // Bit 0 is the first stage that samples d_i; bit STAGES-1 drives q_o.
  // Kept free of any logic between flops so placement can pack them together.
  (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] stage_q;
  logic [STAGES-1:0] stage_d;

  always_comb begin
    stage_d = {stage_q[STAGES-2:0], d_i};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q <= {STAGES{RST_BIT}};
    end else begin
      stage_q <= stage_d;
    end
  end

  assign q_o = stage_q[STAGES-1];

endmodule : sync_cell

// File: rtl/ff_2_sync.sv
// rtl/ff_2_sync.sv - multi-bit flop synchronizer for Gray-coded pointers
// Purpose: brings D1 from a foreign clock domain into the clk domain.
// Ports:
//   clk  - destination-domain clock, rising edge
//   rst  - synchronous active-high reset, loads RST_VAL into every stage
//   D1   - asynchronous data (Gray-coded when multi-bit)
//   ff2  - synchronized data, registered; no combinational path from D1
module ff_2_sync
  import fifo_pkg::*;
#(
  parameter int               Width       = PTR_WIDTH_DEF,
  parameter int               SYNC_STAGES = SYNC_STAGES_DEF,
  parameter logic [Width-1:0] RST_VAL     = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [Width-1:0] D1,
  output logic [Width-1:0] ff2
);

  if (SYNC_STAGES < 2 || Width < 1) begin : g_param_check
    $error("ff_2_sync: SYNC_STAGES must be >= 2 and Width >= 1");
  end

  // Each bit is synchronized on its own; coherency across bits relies on
  // the caller only ever changing one bit at a time (Gray code).
  for (genvar i = 0; i < Width; i++) begin : g_bit
    sync_cell #(
      .STAGES  (SYNC_STAGES),
      .RST_BIT (RST_VAL[i])
    ) u_cell (
      .clk (clk),
      .rst (rst),
      .d_i (D1[i]),
      .q_o (ff2[i])
    );
  end

endmodule : ff_2_sync

// File: tb/tb_ff_2_sync.sv
// tb/tb_ff_2_sync.sv - self-checking bench for ff_2_sync
module tb_ff_2_sync;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] d1;
  logic [3:0] ff2;
  logic       rst_b;
  logic [0:0] d_b;
  logic [0:0] ff2_b;

  always #5 clk = ~clk;

  ff_2_sync #(
    .Width       (4),
    .SYNC_STAGES (2),
    .RST_VAL     (4'b0000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .D1  (d1),
    .ff2 (ff2)
  );

  ff_2_sync #(
    .Width       (1),
    .SYNC_STAGES (3),
    .RST_VAL     (1'b1)
  ) dut_b (
    .clk (clk),
    .rst (rst_b),
    .D1  (d_b),
    .ff2 (ff2_b)
  );

  typedef struct {
    logic       rst;
    logic [3:0] d;
    logic [3:0] exp;
    string      name;
  } vec_t;

  localparam int NVEC = 21;
  vec_t vecs [NVEC];

  typedef struct {
    logic rst;
    logic d;
    logic exp;
  } vec_b_t;

  localparam int NVEC_B = 8;
  vec_b_t vecs_b [NVEC_B];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  // Inputs are driven and outputs sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // rst, D1 applied before the edge; expected ff2 after that edge.
    vecs[0]  = '{1'b1, 4'b1111, 4'b0000, "reset_e1"};
    vecs[1]  = '{1'b1, 4'b1111, 4'b0000, "reset_e2"};
    vecs[2]  = '{1'b0, 4'b0001, 4'b0000, "latency_n"};
    vecs[3]  = '{1'b0, 4'b0001, 4'b0001, "latency_n1"};
    vecs[4]  = '{1'b0, 4'b0000, 4'b0001, "toggle_0"};
    vecs[5]  = '{1'b0, 4'b0001, 4'b0000, "toggle_1"};
    vecs[6]  = '{1'b0, 4'b0000, 4'b0001, "toggle_2"};
    vecs[7]  = '{1'b0, 4'b0001, 4'b0000, "toggle_3"};
    vecs[8]  = '{1'b0, 4'b0000, 4'b0001, "toggle_4"};
    vecs[9]  = '{1'b0, 4'b1010, 4'b0000, "midrst_fill0"};
    vecs[10] = '{1'b0, 4'b1010, 4'b1010, "midrst_fill1"};
    vecs[11] = '{1'b1, 4'b1010, 4'b0000, "midrst_flush"};
    vecs[12] = '{1'b0, 4'b1010, 4'b0000, "midrst_rel0"};
    vecs[13] = '{1'b0, 4'b1010, 4'b1010, "midrst_rel1"};
    vecs[14] = '{1'b1, 4'b0000, 4'b0000, "gray_rst"};
    vecs[15] = '{1'b0, 4'b0000, 4'b0000, "gray_0000"};
    vecs[16] = '{1'b0, 4'b0001, 4'b0000, "gray_0001"};
    vecs[17] = '{1'b0, 4'b0011, 4'b0001, "gray_0011"};
    vecs[18] = '{1'b0, 4'b0010, 4'b0011, "gray_0010"};
    vecs[19] = '{1'b0, 4'b0110, 4'b0010, "gray_0110"};
    vecs[20] = '{1'b0, 4'b0110, 4'b0110, "gray_hold"};

    // Width=1, SYNC_STAGES=3, RST_VAL=1: three edges of latency.
    vecs_b[0] = '{1'b1, 1'b0, 1'b1};
    vecs_b[1] = '{1'b0, 1'b0, 1'b1};
    vecs_b[2] = '{1'b0, 1'b0, 1'b1};
    vecs_b[3] = '{1'b0, 1'b0, 1'b0};
    vecs_b[4] = '{1'b0, 1'b1, 1'b0};
    vecs_b[5] = '{1'b0, 1'b1, 1'b0};
    vecs_b[6] = '{1'b0, 1'b1, 1'b1};
    vecs_b[7] = '{1'b1, 1'b0, 1'b1};

    rst   = 1'b1;
    d1    = 4'b1111;
    rst_b = 1'b1;
    d_b   = 1'b0;
    #1;

    for (int i = 0; i < NVEC; i++) begin
      rst = vecs[i].rst;
      d1  = vecs[i].d;
      tick();
      chk(vecs[i].name, ff2, vecs[i].exp);
    end

    // No combinational path: a D1 change between edges must not move ff2.
    d1 = 4'b1001;
    #3;
    chk("no_comb_path", ff2, 4'b0110);

    // X on D1 while in reset never reaches ff2.
    rst = 1'b1;
    d1  = 4'bxxxx;
    tick();
    chk("x_in_reset_e1", ff2, 4'b0000);
    tick();
    chk("x_in_reset_e2", ff2, 4'b0000);
    rst = 1'b0;
    d1  = 4'b0101;
    tick();
    chk("x_release_n", ff2, 4'b0000);
    tick();
    chk("x_release_n1", ff2, 4'b0101);

    // rst has priority over a changing D1.
    rst = 1'b1;
    d1  = 4'b1111;
    tick();
    chk("rst_priority", ff2, 4'b0000);
    rst = 1'b0;

    // The narrow instance sat in reset for the whole run so far.
    chk("b_reset_held", {3'b000, ff2_b}, 4'b0001);

    for (int i = 0; i < NVEC_B; i++) begin
      rst_b = vecs_b[i].rst;
      d_b   = vecs_b[i].d;
      tick();
      chk($sformatf("b_vec%0d", i), {3'b000, ff2_b}, {3'b000, vecs_b[i].exp});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_ff_2_sync
